// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with a valid/ready handshake on both sides.
// Single-cycle ops finish on the accept edge. MUL, DIVU and REMU run one
// iteration per cycle for WIDTH cycles. Only one operation is in flight at a
// time, and its result is held until the consumer takes it.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_DIVU = 4'b0100;
  localparam logic [3:0] OP_REMU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_XOR  = 4'b1101;

  logic [1:0]       state;
  logic [3:0]       op_q;
  logic [SHW-1:0]   cnt;
  // acc: running product (MUL) or partial remainder (DIV).
  // md:  shifting multiplicand (MUL) or divisor (DIV).
  // mq:  multiplier shifting out LSB-first (MUL) or dividend/quotient (DIV).
  logic [WIDTH-1:0] acc, md, mq;

  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] sub_res;
  logic [WIDTH-1:0] sc_res;
  logic             sc_carry, sc_ovf;
  logic             is_iter;

  logic [WIDTH-1:0] mul_nxt, rem_nxt, quo_nxt, fin_res;
  logic [WIDTH:0]   div_sh, div_diff;
  logic             div_ge;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign shamt    = op2[SHW-1:0];
  assign add_full = {1'b0, op1} + {1'b0, op2};
  assign sub_res  = op1 - op2;
  assign is_iter  = (alu_op == OP_MUL) || (alu_op == OP_DIVU) || (alu_op == OP_REMU);

  // Single-cycle result and arithmetic flags from the live operand inputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path through the case infers a latch.
    sc_res   = add_full[WIDTH-1:0];
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    case (alu_op)
      OP_AND:  sc_res = op1 & op2;
      OP_OR:   sc_res = op1 | op2;
      OP_XOR:  sc_res = op1 ^ op2;
      OP_SUB: begin
        sc_res   = sub_res;
        sc_carry = (op1 < op2);
        sc_ovf   = (op1[WIDTH-1] != op2[WIDTH-1]) && (sub_res[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (op1 < op2)};
      OP_SRL:  sc_res = op1 >> shamt;
      OP_SLL:  sc_res = op1 << shamt;
      OP_SRA:  sc_res = $unsigned($signed(op1) >>> shamt);
      OP_MUL, OP_DIVU, OP_REMU: sc_res = '0;  // handled by the iterative path
      default: begin  // ADD and the unused codes that alias to it
        sc_carry = add_full[WIDTH];
        sc_ovf   = (op1[WIDTH-1] == op2[WIDTH-1]) && (add_full[WIDTH-1] != op1[WIDTH-1]);
      end
    endcase
  end

  // One shift-add step and one restoring-divide step. A zero divisor always
  // passes the compare, so DIVU yields all ones and REMU yields op1.
  assign mul_nxt  = acc + (mq[0] ? md : '0);
  assign div_sh   = {acc, mq[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, md};
  assign div_ge   = (div_sh >= {1'b0, md});
  assign rem_nxt  = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
  assign quo_nxt  = {mq[WIDTH-2:0], div_ge};

  // Pick the iterative result that the final step produces.
  always_comb begin
    case (op_q)
      OP_MUL:  fin_res = mul_nxt;
      OP_REMU: fin_res = rem_nxt;
      default: fin_res = quo_nxt;
    endcase
  end

  // Control FSM plus the datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
      state    <= IDLE;
      op_q     <= '0;
      cnt      <= '0;
      acc      <= '0;
      md       <= '0;
      mq       <= '0;
      result   <= '0;
      zero     <= 1'b0;
      negative <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q <= alu_op;
            if (is_iter) begin
              acc   <= '0;
              cnt   <= SHW'(WIDTH - 1);
              state <= BUSY;
              if (alu_op == OP_MUL) begin
                md <= op1;
                mq <= op2;
              end else begin
                md <= op2;
                mq <= op1;
              end
            end else begin
              result   <= sc_res;
              zero     <= (sc_res == '0);
              negative <= sc_res[WIDTH-1];
              carry    <= sc_carry;
              overflow <= sc_ovf;
              state    <= DONE;
            end
          end
        end
        BUSY: begin
          if (op_q == OP_MUL) begin
            acc <= mul_nxt;
            md  <= md << 1;
            mq  <= mq >> 1;
          end else begin
            acc <= rem_nxt;
            mq  <= quo_nxt;
          end
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            result   <= fin_res;
            zero     <= (fin_res == '0);
            negative <= fin_res[WIDTH-1];
            carry    <= 1'b0;
            overflow <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a WIDTH=32 instance and a WIDTH=8 instance
// share clock, reset, operands and out_ready, and each has its own in_valid.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] op1, op2;
  logic [3:0]  alu_op;
  logic        out_ready;

  logic        iv_a, ir_a, ov_a, z_a, n_a, c_a, v_a;
  logic [31:0] res_a;
  logic        iv_b, ir_b, ov_b, z_b, n_b, c_b, v_b;
  logic [7:0]  res_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(ir_a),
    .op1(op1), .op2(op2), .alu_op(alu_op), .out_valid(ov_a), .out_ready(out_ready),
    .result(res_a), .zero(z_a), .negative(n_a), .carry(c_a), .overflow(v_a)
  );

  alu_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir_b),
    .op1(op1[7:0]), .op2(op2[7:0]), .alu_op(alu_op), .out_valid(ov_b), .out_ready(out_ready),
    .result(res_b), .zero(z_b), .negative(n_b), .carry(c_b), .overflow(v_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, measure latency, check result/flags, then hand it off.
  task automatic run(input string tag, input bit w8, input logic [3:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] er, input logic [3:0] ef, input int el);
    int lat;
    bit got;
    for (int i = 0; i < 50; i++) begin
      if (w8 ? ir_b : ir_a) break;
      @(posedge clk); #1;
    end
    @(negedge clk);
    alu_op = op; op1 = a; op2 = b;
    if (w8) iv_b = 1'b1; else iv_a = 1'b1;
    @(posedge clk); #1;
    iv_a = 1'b0; iv_b = 1'b0;
    op1 = $urandom; op2 = $urandom; alu_op = 4'($urandom);
    lat = 1; got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (w8 ? ov_b : ov_a) begin got = 1'b1; break; end
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, got ? lat : -1, el);
    check({tag, "_res"}, w8 ? {56'b0, res_b} : {32'b0, res_a}, {32'b0, er});
    check({tag, "_flags"}, w8 ? {z_b, n_b, c_b, v_b} : {z_a, n_a, c_a, v_a}, ef);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check({tag, "_drop"}, w8 ? {ov_b, ir_b} : {ov_a, ir_a}, 2'b01);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; iv_a = 1'b0; iv_b = 1'b0; out_ready = 1'b0;
    op1 = '0; op2 = '0; alu_op = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a", {ir_a, ov_a, res_a, z_a, n_a, c_a, v_a}, {2'b10, 32'h0, 4'b0000});
    check("rst_b", {ir_b, ov_b, res_b, z_b, n_b, c_b, v_b}, {2'b10, 8'h0, 4'b0000});
    @(negedge clk); rst_n = 1'b1;

    // Logic, add/sub flags and their boundaries
    run("and",   0, 4'b0000, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 4'b0000, 1);
    run("or",    0, 4'b0001, 32'hFF00FF00, 32'h0FF00FF0, 32'hFFF0FFF0, 4'b0100, 1);
    run("add_c", 0, 4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1010, 1);
    run("add_v", 0, 4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0101, 1);
    run("sub_v", 0, 4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0001, 1);
    run("sub_b", 0, 4'b0110, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b0110, 1);

    // Async reset in the middle of a DIVU; result/flags were nonzero before
    @(negedge clk);
    alu_op = 4'b0100; op1 = 32'd1000; op2 = 32'd3; iv_a = 1'b1;
    @(posedge clk); #1; iv_a = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("busy_ready", {ir_a, ov_a}, 2'b00);
    #1; rst_n = 1'b0;
    #1;
    check("mid_rst", {ir_a, ov_a, res_a, z_a, n_a, c_a, v_a}, {2'b10, 32'h0, 4'b0000});
    @(negedge clk); rst_n = 1'b1;
    run("add_post_rst", 0, 4'b0010, 32'd5, 32'd7, 32'd12, 4'b0000, 1);

    // Compares and shifts
    run("slt",   0, 4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000, 1);
    run("sltu",  0, 4'b1011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1000, 1);
    run("sra",   0, 4'b1010, 32'h80000000, 32'h00000024, 32'hF8000000, 4'b0100, 1);
    run("srl",   0, 4'b1000, 32'h80000000, 32'h00000004, 32'h08000000, 4'b0000, 1);
    run("sll",   0, 4'b1001, 32'h00000001, 32'h0000001F, 32'h80000000, 4'b0100, 1);

    // Iterative ops
    run("mul0",  0, 4'b0011, 32'h00010000, 32'h00010000, 32'h00000000, 4'b1000, 33);
    run("mul",   0, 4'b0011, 32'h00010003, 32'h00000005, 32'h0005000F, 4'b0000, 33);
    run("divu",  0, 4'b0100, 32'd100, 32'd7, 32'd14, 4'b0000, 33);
    run("remu",  0, 4'b0101, 32'd100, 32'd7, 32'd2, 4'b0000, 33);
    run("divu_big", 0, 4'b0100, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 4'b0000, 33);
    run("remu_big", 0, 4'b0101, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 4'b0000, 33);
    run("divu_z", 0, 4'b0100, 32'd9, 32'd0, 32'hFFFFFFFF, 4'b0100, 33);
    run("remu_z", 0, 4'b0101, 32'd9, 32'd0, 32'd9, 4'b0000, 33);

    // Backpressure: result held while in_valid pulses with new operands
    @(negedge clk);
    alu_op = 4'b1101; op1 = 32'hF0F0F0F0; op2 = 32'hFF00FF00; iv_a = 1'b1;
    @(posedge clk); #1; iv_a = 1'b0;
    check("xor_res", {ov_a, ir_a, res_a}, {2'b10, 32'h0FF00FF0});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      iv_a = i[0]; op1 = $urandom; op2 = $urandom; alu_op = 4'b0000;
      @(posedge clk); #1;
      check("bp_hold", {ov_a, ir_a, res_a, z_a, n_a, c_a, v_a}, {2'b10, 32'h0FF00FF0, 4'b0000});
    end
    iv_a = 1'b0;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check("bp_release", {ov_a, ir_a}, 2'b01);

    // Aliased opcode behaves as ADD
    run("alias_e", 0, 4'b1110, 32'd2, 32'd3, 32'd5, 4'b0000, 1);
    run("alias_c", 0, 4'b1100, 32'hFFFFFFFF, 32'd2, 32'd1, 4'b0010, 1);

    // WIDTH=8 instance
    run("mul8",  1, 4'b0011, 32'd16, 32'd16, 32'h00, 4'b1000, 9);
    run("divu8", 1, 4'b0100, 32'd200, 32'd3, 32'd66, 4'b0000, 9);
    run("remu8", 1, 4'b0101, 32'd200, 32'd3, 32'd2, 4'b0000, 9);
    run("add8",  1, 4'b0010, 32'hFF, 32'h01, 32'h00, 4'b1010, 1);
    run("sra8",  1, 4'b1010, 32'h80, 32'h0B, 32'hF0, 4'b0100, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
